// File: rtl/x25519_pkg.sv
// x25519_pkg: shared widths and scalar helpers for the x25519 frame loader
package x25519_pkg;
    localparam int FIELD_BITS = 255;
    localparam int FRAME_BYTES = 64;
    localparam int SCALAR_BYTES = 32;
    typedef enum logic {LOAD, DRAIN} asm_state_t;
    function automatic logic [FIELD_BITS-1:0] clamp(input logic [8*SCALAR_BYTES-1:0] s, input logic en);
        return en ? {1'b1, s[253:3], 3'b000} : s[FIELD_BITS-1:0];
    endfunction
    function automatic logic [FIELD_BITS-1:0] field_of(input logic [8*SCALAR_BYTES-1:0] v);
        return v[FIELD_BITS-1:0];
    endfunction
endpackage

// File: rtl/x25519_loader_if.sv
// x25519_loader_if: byte-stream input and curve25519 core handshake bundle
interface x25519_loader_if;
    import x25519_pkg::*;
    logic [7:0] in_data;
    logic in_valid;
    logic in_last;
    logic in_ready;
    logic core_start;
    logic [FIELD_BITS-1:0] core_n;
    logic [FIELD_BITS-1:0] core_q;
    logic core_done;
    logic busy;
    logic frame_err;
    modport master (
        output in_data, in_valid, in_last, core_done,
        input in_ready, core_start, core_n, core_q, busy, frame_err
    );
    modport slave (
        input in_data, in_valid, in_last, core_done,
        output in_ready, core_start, core_n, core_q, busy, frame_err
    );
endinterface

// File: rtl/x25519_byte_assembler.sv
// x25519_byte_assembler: collects 64-byte frames and flags framing errors
module x25519_byte_assembler
    import x25519_pkg::*;
(
    input logic clock,
    input logic reset_n,
    input logic [7:0] in_data,
    input logic in_valid,
    input logic in_last,
    input logic hold,
    output logic in_ready,
    output logic frame_done,
    output logic frame_err,
    output logic [8*FRAME_BYTES-1:0] frame
);
    asm_state_t state, state_nx;
    logic [5:0] count, count_nx;
    logic live, accept, at_end, err_nx;
    assign in_ready = live & ~hold;
    assign accept = in_valid & in_ready;
    assign at_end = count == 6'(FRAME_BYTES - 1);
    assign frame_done = accept & (state == LOAD) & at_end & in_last;
    always_comb begin
        state_nx = state;
        count_nx = count;
        err_nx = 1'b0;
        if (accept && state == DRAIN) begin
            state_nx = in_last ? LOAD : DRAIN;
        end else if (accept) begin
            count_nx = (in_last || at_end) ? 6'd0 : count + 6'd1;
            state_nx = (at_end && !in_last) ? DRAIN : LOAD;
            err_nx = in_last ^ at_end;
        end
    end
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= LOAD;
            count <= 6'd0;
            live <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            live <= 1'b1;
            frame_err <= err_nx;
        end
    end
    // buffer needs no reset: every byte is rewritten before a frame can complete
    always_ff @(posedge clock) begin
        if (accept && state == LOAD) frame[{count, 3'b000} +: 8] <= in_data;
    end
endmodule

// File: rtl/x25519_loader.sv
// x25519_loader: frames serial bytes into scalar/u-coordinate and issues core operations
module x25519_loader
    import x25519_pkg::*;
#(
    parameter bit CLAMP = 1'b1
) (
    input logic clock,
    input logic reset_n,
    x25519_loader_if.slave bus
);
    logic [8*FRAME_BYTES-1:0] frame;
    logic frame_done, pending, busy_q, start_q, issue;
    logic [FIELD_BITS-1:0] n_q, q_q;
    x25519_byte_assembler u_asm (
        .clock(clock),
        .reset_n(reset_n),
        .in_data(bus.in_data),
        .in_valid(bus.in_valid),
        .in_last(bus.in_last),
        .hold(pending),
        .in_ready(bus.in_ready),
        .frame_done(frame_done),
        .frame_err(bus.frame_err),
        .frame(frame)
    );
    // issue only from registered busy so core_done never reaches core_start combinationally
    assign issue = pending & ~busy_q;
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pending <= 1'b0;
            busy_q <= 1'b0;
            start_q <= 1'b0;
            n_q <= '0;
            q_q <= '0;
        end else begin
            start_q <= issue;
            pending <= frame_done | (pending & ~issue);
            busy_q <= issue | (busy_q & ~bus.core_done);
            if (issue) begin
                n_q <= clamp(frame[8*SCALAR_BYTES-1:0], CLAMP);
                q_q <= field_of(frame[8*FRAME_BYTES-1:8*SCALAR_BYTES]);
            end
        end
    end
    assign bus.core_start = start_q;
    assign bus.busy = busy_q;
    assign bus.core_n = n_q;
    assign bus.core_q = q_q;
endmodule

// File: doc/x25519_loader.md
X25519_LOADER -- requirements
Module: x25519_loader

Interface
REQ-001 Parameter CLAMP, default 1: 1 applies scalar clamping per REQ-012; 0 passes scalar bits [254:0] unmodified.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 in_data  input  8  serial frame byte.
REQ-005 in_valid  input  1  in_data/in_last valid this cycle.
REQ-006 in_last  input  1  marks final byte of a frame.
REQ-007 in_ready  output  1  byte accepted when in_valid & in_ready.
REQ-008 core_start  output  1  one-cycle start pulse to the curve25519 core.
REQ-009 core_n, core_q  output  255 each  scalar and u-coordinate to the core.
REQ-010 core_done  input  1  completion pulse from the core.
REQ-011 busy, frame_err  output  1 each  core operation outstanding; one-cycle framing-error pulse.

Function
REQ-012 Frame = 64 bytes, little-endian: bytes 0-31 scalar s, byte k into s[8k+7:8k]; bytes 32-63 u likewise; CLAMP=1 gives n = {1, s[253:3], 000}; q = u[254:0] (u[255] dropped).
REQ-013 A byte counter 0..63 advances on each accepted byte; states: LOAD, DRAIN.
REQ-014 in_last on byte 63 completes the frame and sets pending; counter returns to 0.
REQ-015 in_last on any byte < 63: frame discarded, counter to 0, frame_err pulses the next cycle, no start issued.
REQ-016 Byte 63 without in_last: frame discarded, frame_err pulses the next cycle, enter DRAIN; DRAIN accepts and drops bytes until one carrying in_last is accepted, then returns to LOAD with counter 0.
REQ-017 in_ready = 0 while pending = 1; otherwise 1 (both LOAD and DRAIN), except during reset.
REQ-018 When pending & !busy: core_n/core_q load from the assembly buffer, core_start = 1 for exactly one cycle, busy set, pending cleared, all in the same edge.
REQ-019 Latency: last byte accepted at edge t with busy = 0 -> core_start high during cycle t+1.
REQ-020 core_n/core_q are held constant from core_start until the next core_start, including after core_done.
REQ-021 A new frame is assembled while busy = 1 (prefetch); its pending state waits for core_done.
REQ-022 core_done with busy = 1 clears busy; if pending, core_start issues in the following cycle (earliest t+1 after core_done at t); no combinational path from core_done to core_start.
REQ-023 core_done with busy = 0 is ignored.
REQ-024 Frame completion and core_done in the same cycle: both take effect; start follows next cycle.
REQ-025 core_start never asserts while busy = 1.

Reset
REQ-026 While reset_n = 0 at an edge: counter 0, state LOAD, pending 0, busy 0, core_start 0, frame_err 0, core_n 0, core_q 0, in_ready 0.
REQ-027 in_ready = 1 the first cycle after reset_n returns high.
REQ-028 Reset mid-frame or mid-operation discards the partial frame and any pending frame; a later core_done is ignored per REQ-023.

Structure
REQ-029 Shared package x25519_pkg holds FIELD_BITS = 255, FRAME_BYTES = 64, SCALAR_BYTES = 32, and the clamp function.
REQ-030 One sub-module is permitted: x25519_byte_assembler (counter, LOAD/DRAIN, buffer, framing errors); the issue/busy logic stays in x25519_loader.

Verification
REQ-031 32 bytes 0x00, then 0x09 and 31 bytes 0x00, in_last on byte 63 -> core_n = 0x4000…0000, core_q = 9, one core_start pulse at t+1.
REQ-032 64 bytes 0xFF -> core_n = 0x7FFF…FFF8, core_q = 2^255-1; CLAMP=0 -> core_n = 2^255-1.
REQ-033 in_last on byte 10 -> frame_err one cycle, no start; the next valid frame issues normally.
REQ-034 Two frames back-to-back, core_done 200 cycles after the first start -> in_ready low after byte 63 of frame 2; second start exactly 1 cycle after core_done; core_n/core_q unchanged until then.
REQ-035 reset_n low for 1 cycle at byte 40, then a full frame -> only one start, carrying the post-reset frame's values; a stale core_done is ignored.
REQ-036 64 bytes without in_last, then 5 bytes with in_last on the 5th -> frame_err once, no start; the next frame issues normally.
